mdu_seq: RTL and testbench

Multiply/divide sequencer for the MIPS five-stage pipeline. It sits beside the execute stage. It accepts DIV/DIVU, optional MULT/MULTU, and MTHI/MTLO requests, and runs a 32-iteration restoring divider. It owns the HI/LO registers and raises a stall that the execute stage folds into its ready-go. Exception flush cancels any in-flight operation without touching HI/LO.

---
 rtl/mdu_seq.sv | 143 ++++++++++++++
 tb/tb_mdu_seq.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_seq.sv
// mdu_seq: HI/LO owner with a 32-step restoring divider and stall to execute.
// Define MDU_MULT_EN to add single-cycle MULT/MULTU through the MUL state.
module mdu_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

`ifdef MDU_MULT_EN
  typedef enum logic [1:0] {IDLE, RUN, FIX, MUL} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
`endif

  localparam logic [2:0] OP_DIV  = 3'd1;
  localparam logic [2:0] OP_DIVU = 3'd2;
  localparam logic [2:0] OP_MTHI = 3'd5;
  localparam logic [2:0] OP_MTLO = 3'd6;

  state_t      state;
  logic [5:0]  cnt;
  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] dvs;
  logic        q_neg;
  logic        r_neg;
  logic        is_div;
  logic        is_mul;
  logic        is_long;
  logic        a_neg;
  logic        b_neg;
  logic [32:0] shift;
  logic [32:0] trial;

  assign is_div = (req_op == OP_DIV) || (req_op == OP_DIVU);

`ifdef MDU_MULT_EN
  localparam logic [2:0] OP_MULT  = 3'd3;
  localparam logic [2:0] OP_MULTU = 3'd4;

  logic        m_sgn;
  logic [63:0] m_a;
  logic [63:0] m_b;
  logic [63:0] prod;

  assign is_mul = (req_op == OP_MULT) || (req_op == OP_MULTU);
  // low 64 bits of a 64x64 product are correct for both signednesses
  assign m_a  = m_sgn ? {{32{quo[31]}}, quo} : {32'b0, quo};
  assign m_b  = m_sgn ? {{32{dvs[31]}}, dvs} : {32'b0, dvs};
  assign prod = m_a * m_b;
  assign done = ~flush & ((state == FIX) | (state == MUL));
`else
  assign is_mul = 1'b0;
  assign done   = ~flush & (state == FIX);
`endif

  assign is_long = is_div | is_mul;
  assign a_neg   = (req_op == OP_DIV) & req_src1[31];
  assign b_neg   = (req_op == OP_DIV) & req_src2[31];

  // quotient shifts out of quo into the partial remainder
  assign shift = {rem, quo[31]};
  assign trial = shift - {1'b0, dvs};

  assign stall = ((state == IDLE) & req_valid & is_long & ~flush)
               | (state == RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
`ifdef MDU_MULT_EN
      m_sgn <= 1'b0;
`endif
    end else if (flush) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            unique case (1'b1)
              is_div: begin
                quo   <= a_neg ? -req_src1 : req_src1;
                dvs   <= b_neg ? -req_src2 : req_src2;
                q_neg <= a_neg ^ b_neg;
                r_neg <= a_neg;
                rem   <= '0;
                cnt   <= '0;
                state <= RUN;
              end
`ifdef MDU_MULT_EN
              is_mul: begin
                quo   <= req_src1;
                dvs   <= req_src2;
                m_sgn <= (req_op == OP_MULT);
                state <= MUL;
              end
`endif
              (req_op == OP_MTHI): hi <= req_src1;
              (req_op == OP_MTLO): lo <= req_src1;
              default: ;
            endcase
          end
        end
        RUN: begin
          rem <= trial[32] ? shift[31:0] : trial[31:0];
          quo <= {quo[30:0], ~trial[32]};
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31)
            state <= FIX;
        end
        FIX: begin
          lo    <= q_neg ? -quo : quo;
          hi    <= r_neg ? -rem : rem;
          state <= IDLE;
        end
`ifdef MDU_MULT_EN
        MUL: begin
          {hi, lo} <= prod;
          state    <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: directed and random requests against an arithmetic HI/LO model.
// Honors MDU_MULT_EN the same way the design does.
module tb_mdu_seq;

`ifdef MDU_MULT_EN
  localparam bit MULT_EN = 1'b1;
`else
  localparam bit MULT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic [2:0]  req_op = '0;
  logic [31:0] req_src1 = '0;
  logic [31:0] req_src2 = '0;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int          errors = 0;
  int          checks = 0;
  bit          chk_en = 1'b0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  mdu_seq dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .req_valid(req_valid),
    .req_op   (req_op),
    .req_src1 (req_src1),
    .req_src2 (req_src2),
    .stall    (stall),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // HI/LO result straight from the arithmetic definition
  function automatic logic [63:0] ref_hilo(input logic [2:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    longint sa, sb, ma, mb, q, r;
    logic [63:0] p;
    p = '0;
    case (op)
      3'd2: begin
        if (b == 0) p = {a, 32'hFFFFFFFF};
        else        p = {a % b, a / b};
      end
      3'd1: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ma = (sa < 0) ? -sa : sa;
        mb = (sb < 0) ? -sb : sb;
        if (mb == 0) begin
          q = 64'hFFFFFFFF;
          r = ma;
        end else begin
          q = ma / mb;
          r = ma % mb;
        end
        if ((sa < 0) != (sb < 0)) q = -q;
        if (sa < 0) r = -r;
        p = {r[31:0], q[31:0]};
      end
      3'd3: p = 64'(longint'($signed(a)) * longint'($signed(b)));
      3'd4: p = {32'b0, a} * {32'b0, b};
      default: p = '0;
    endcase
    return p;
  endfunction

  // continuous HI/LO check against the model
  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (hi !== exp_hi || lo !== exp_lo) begin
        errors++;
        $display("FAIL hilo @%0t: got %h/%h expected %h/%h",
                 $time, hi, lo, exp_hi, exp_lo);
      end
    end
  end

  // called at posedge+1; f = cycle index to flush on, -1 for none
  task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int f);
    bit is_div, is_mul, is_long, fin;
    int lat, n, sc, nd, dc, exp_sc, exp_nd;
    is_div  = (op == 3'd1) || (op == 3'd2);
    is_mul  = MULT_EN && ((op == 3'd3) || (op == 3'd4));
    is_long = is_div || is_mul;
    lat     = is_div ? 33 : (is_mul ? 1 : 0);
    if (!is_long)    exp_sc = 0;
    else if (f < 0)  exp_sc = lat;
    else if (f == 0) exp_sc = 0;
    else             exp_sc = (f + 1 < lat) ? f + 1 : lat;
    exp_nd = (is_long && (f < 0 || f > lat)) ? 1 : 0;
    req_valid = 1'b1;
    req_op    = op;
    req_src1  = a;
    req_src2  = b;
    n = 0; sc = 0; nd = 0; dc = -1; fin = 1'b0;
    while (!fin) begin
      if (n >= 60) begin
        checks++;
        errors++;
        $display("FAIL timeout: op %0d still stalling after %0d cycles", op, n);
        break;
      end
      flush = (n == f);
      @(negedge clk);
      if (stall) sc++;
      if (done) begin
        nd++;
        dc = n;
      end
      fin = !stall || flush;
      @(posedge clk);
      #1;
      n++;
    end
    req_valid = 1'b0;
    flush     = 1'b0;
    chk($sformatf("stall cycles op%0d", op), sc, exp_sc);
    chk($sformatf("done count op%0d", op), nd, exp_nd);
    if (exp_nd == 1) begin
      chk($sformatf("done cycle op%0d", op), dc, lat);
      {exp_hi, exp_lo} = ref_hilo(op, a, b);
    end else if (op == 3'd5) begin
      exp_hi = a;
    end else if (op == 3'd6) begin
      exp_lo = a;
    end
  endtask

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [2:0] op;
    int f;
    repeat (3) @(posedge clk);
    #1;
    reset  = 1'b0;
    chk_en = 1'b1;
    chk("reset hi", hi, 32'h0);
    chk("reset lo", lo, 32'h0);
    chk("reset stall", 32'(stall), 32'h0);
    chk("reset done", 32'(done), 32'h0);

    run_op(3'd5, 32'h1234, 32'h0, -1);
    run_op(3'd6, 32'h5678, 32'h0, -1);
    chk("mthi", hi, 32'h1234);
    chk("mtlo", lo, 32'h5678);

    run_op(3'd2, 32'd100, 32'd7, -1);
    chk("divu 100/7 hi", hi, 32'd2);
    chk("divu 100/7 lo", lo, 32'd14);

    run_op(3'd1, 32'hFFFFFFF9, 32'd2, -1);
    chk("div -7/2 hi", hi, 32'hFFFFFFFF);
    chk("div -7/2 lo", lo, 32'hFFFFFFFD);

    run_op(3'd1, 32'h80000000, 32'hFFFFFFFF, -1);
    chk("div ovf hi", hi, 32'h0);
    chk("div ovf lo", lo, 32'h80000000);

    run_op(3'd2, 32'd5, 32'd0, -1);
    chk("divu 5/0 hi", hi, 32'd5);
    chk("divu 5/0 lo", lo, 32'hFFFFFFFF);

    run_op(3'd5, 32'h1234, 32'h0, -1);
    run_op(3'd6, 32'h5678, 32'h0, -1);
    run_op(3'd1, 32'd100, 32'd7, 10);
    @(negedge clk);
    chk("post-flush stall", 32'(stall), 32'h0);
    chk("post-flush done", 32'(done), 32'h0);
    chk("flush hi", hi, 32'h1234);
    chk("flush lo", lo, 32'h5678);
    @(posedge clk);
    #1;

    run_op(3'd3, 32'hFFFFFFFF, 32'd3, -1);
    chk("mult hi", hi, MULT_EN ? 32'hFFFFFFFF : 32'h1234);
    chk("mult lo", lo, MULT_EN ? 32'hFFFFFFFD : 32'h5678);
    run_op(3'd4, 32'hFFFFFFFF, 32'd3, -1);
    chk("multu hi", hi, MULT_EN ? 32'h2 : 32'h1234);
    chk("multu lo", lo, MULT_EN ? 32'hFFFFFFFD : 32'h5678);

    run_op(3'd5, 32'hAAAA, 32'h0, -1);
    req_valid = 1'b1;
    req_op    = 3'd2;
    req_src1  = 32'd1000;
    req_src2  = 32'd3;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    reset     = 1'b1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    exp_hi = '0;
    exp_lo = '0;
    reset  = 1'b0;
    @(negedge clk);
    chk("rst hi", hi, 32'h0);
    chk("rst lo", lo, 32'h0);
    chk("rst stall", 32'(stall), 32'h0);
    chk("rst done", 32'(done), 32'h0);
    @(posedge clk);
    #1;
    run_op(3'd2, 32'd9, 32'd3, -1);
    chk("divu 9/3 hi", hi, 32'h0);
    chk("divu 9/3 lo", lo, 32'd3);

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      f  = -1;
      if ((op == 3'd1 || op == 3'd2) && $urandom_range(0, 4) == 0)
        f = $urandom_range(0, 33);
      else if ((op == 3'd3 || op == 3'd4) && $urandom_range(0, 4) == 0)
        f = $urandom_range(0, 1);
      run_op(op, rnd32(), rnd32(), f);
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
